im_program_loader: RTL and testbench

//  Byte-stream writer that fills the 1K x 16 instruction memory the calc core fetches from.

---
 rtl/im_program_loader.sv | 160 ++++++++++++++++
 tb/tb_im_program_loader.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/im_program_loader.sv
// Purpose: turns a framed host byte stream (len, words, xor checksum) into IM writes; holds the core in reset until the frame verifies.
// Latency: a word is written (im_we) the cycle after its low byte; core_hold drops the cycle after the checksum byte.
// Backpressure: in_ready is high in every byte-accepting state, so the loader takes 1 byte/cycle and never stalls the host mid-frame.
module im_program_loader #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 16,
    parameter int MAX_WORDS = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] im_addr,
    output logic [DATA_W-1:0] im_wdata,
    output logic              im_we,
    output logic              core_hold,
    output logic              busy,
    output logic              done,
    output logic              error,
    output logic [10:0]       words_loaded
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_HI = 3'd1;
    localparam logic [2:0] S_LEN_LO = 3'd2;
    localparam logic [2:0] S_W_HI   = 3'd3;
    localparam logic [2:0] S_W_LO   = 3'd4;
    localparam logic [2:0] S_CHK    = 3'd5;
    localparam logic [2:0] S_DONE   = 3'd6;
    localparam logic [2:0] S_ERROR  = 3'd7;

    localparam logic [15:0] MAX_LEN = 16'(MAX_WORDS);

    logic [2:0]      state;
    logic [15:0]     len_q;      // frame length N, valid once LEN_LO is taken
    logic [7:0]      hi_q;       // pending high byte (length or word)
    logic [7:0]      chk_q;      // running XOR of every byte in the frame so far
    logic [ADDR_W:0] idx_q;      // index of the next word to be written

    logic        xfer;
    logic        can_start;
    logic [15:0] len_n;
    logic        len_bad;
    logic        last_word;
    logic        chk_ok;

    // Handshake and decode of the current byte against the running frame state.
    always_comb begin
        in_ready = 1'b0;
        busy     = 1'b0;
        case (state)
            S_LEN_HI, S_LEN_LO, S_W_HI, S_W_LO, S_CHK: begin
                in_ready = 1'b1;
                busy     = 1'b1;
            end
            default: begin
                in_ready = 1'b0;
                busy     = 1'b0;
            end
        endcase
    end

    assign xfer      = in_valid & in_ready;
    // start is only honoured when no frame is in flight.
    assign can_start = start & ~busy;
    assign len_n     = {hi_q, in_data};
    assign len_bad   = (len_n == 16'd0) || (len_n > MAX_LEN);
    assign last_word = (16'(idx_q) == (len_q - 16'd1));
    // The checksum byte must equal the XOR of everything before it.
    assign chk_ok    = (in_data == chk_q);

    // Frame sequencer: every byte-state arrow waits for a transfer, no timeout.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE, S_DONE, S_ERROR: if (start) state <= S_LEN_HI;
                S_LEN_HI: if (xfer) state <= S_LEN_LO;
                S_LEN_LO: if (xfer) state <= len_bad ? S_ERROR : S_W_HI;
                S_W_HI:   if (xfer) state <= S_W_LO;
                S_W_LO:   if (xfer) state <= last_word ? S_CHK : S_W_HI;
                S_CHK:    if (xfer) state <= chk_ok ? S_DONE : S_ERROR;
                default:  state <= S_IDLE;
            endcase
        end
    end

    // Frame bookkeeping: length capture, high-byte staging, checksum and word index.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            len_q <= '0;
            hi_q  <= '0;
            chk_q <= '0;
            idx_q <= '0;
        end else if (can_start) begin
            len_q <= '0;
            chk_q <= '0;
            idx_q <= '0;
        end else if (xfer) begin
            chk_q <= chk_q ^ in_data;
            if (state == S_LEN_HI || state == S_W_HI)
                hi_q <= in_data;
            if (state == S_LEN_LO)
                len_q <= len_n;
            if (state == S_W_LO)
                idx_q <= idx_q + 1'b1;
        end
    end

    // IM write port: one-cycle strobe after each completed word; the length
    // check guarantees the index never exceeds the memory, so no wrap logic.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            im_we        <= 1'b0;
            im_addr      <= '0;
            im_wdata     <= '0;
            words_loaded <= '0;
        end else begin
            im_we <= 1'b0;
            if (can_start) begin
                words_loaded <= '0;
            end else if (xfer && state == S_W_LO) begin
                im_we    <= 1'b1;
                im_addr  <= idx_q[ADDR_W-1:0];
                im_wdata <= DATA_W'({hi_q, in_data});
                // Counter moves with the strobe so it reads N on the last write.
                if (16'(words_loaded) < len_q)
                    words_loaded <= words_loaded + 11'd1;
            end
        end
    end

    // Sticky result flags and core reset control.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done      <= 1'b0;
            error     <= 1'b0;
            core_hold <= 1'b1;
        end else if (can_start) begin
            done      <= 1'b0;
            error     <= 1'b0;
            core_hold <= 1'b1;
        end else if (xfer) begin
            if (state == S_LEN_LO && len_bad)
                error <= 1'b1;
            if (state == S_CHK) begin
                if (chk_ok) begin
                    done      <= 1'b1;
                    core_hold <= 1'b0;
                end else begin
                    error <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_im_program_loader.sv
// Purpose: scoreboard bench for im_program_loader; expected IM writes are queued as words are sent.
// Latency: checks each write on the strobe cycle and frame results a few cycles after the checksum byte.
// Backpressure: optional random idle gaps between bytes; every handshake wait is bounded.
module tb_im_program_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [9:0]  im_addr;
    logic [15:0] im_wdata;
    logic        im_we;
    logic        core_hold;
    logic        busy;
    logic        done;
    logic        error;
    logic [10:0] words_loaded;

    im_program_loader #(.ADDR_W(10), .DATA_W(16), .MAX_WORDS(1024)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .im_addr      (im_addr),
        .im_wdata     (im_wdata),
        .im_we        (im_we),
        .core_hold    (core_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [25:0] sb[$];          // {addr, data} of each expected IM write
    logic [25:0] sb_e;
    int          we_cnt;
    logic [9:0]  last_addr;
    bit          gaps;
    logic [7:0]  run_chk;
    logic [15:0] words[0:1023];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst === 1'b1 && im_we === 1'b1) begin
            if (sb.size() == 0) begin
                check("unexpected_we", 32'(im_addr), 32'hFFFF_FFFF);
            end else begin
                sb_e = sb.pop_front();
                check("we_addr", 32'(im_addr), 32'(sb_e[25:16]));
                check("we_data", 32'(im_wdata), 32'(sb_e[15:0]));
            end
            check("wl_on_we", 32'(words_loaded), 32'(we_cnt + 1));
            we_cnt++;
            last_addr = im_addr;
        end
    end

    // Called at #1 after a rising edge; returns at #1 after the edge that took the byte.
    task automatic send_byte(input logic [7:0] b);
        int  n;
        bit  taken;
        if (gaps) begin
            n = $urandom_range(0, 3);
            repeat (n) begin
                @(posedge clk);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        run_chk  = run_chk ^ b;
        taken    = 1'b0;
        n        = 0;
        while (!taken && n < 50) begin
            @(negedge clk);
            if (in_ready) taken = 1'b1;
            @(posedge clk);
            #1;
            n++;
        end
        if (!taken) check("xfer_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic send_frame(input int n, input bit bad, input logic [7:0] bad_byte, input bit mid_start);
        logic [15:0] len;
        logic [7:0]  c;
        logic [9:0]  a;
        len     = 16'(n);
        run_chk = 8'h00;
        we_cnt  = 0;
        send_byte(len[15:8]);
        send_byte(len[7:0]);
        if (mid_start) begin
            pulse_start();
            check("busy_after_ignored_start", 32'(busy), 32'd1);
            check("hold_after_ignored_start", 32'(core_hold), 32'd1);
        end
        for (int i = 0; i < n; i++) begin
            a = i[9:0];
            send_byte(words[i][15:8]);
            sb.push_back({a, words[i]});
            send_byte(words[i][7:0]);
        end
        c = run_chk;
        send_byte(bad ? bad_byte : c);
    endtask

    task automatic end_check(input string tag, input bit exp_done, input int n);
        repeat (3) @(posedge clk);
        #1;
        check({tag, "_done"},  32'(done),         32'(exp_done));
        check({tag, "_error"}, 32'(error),        32'(!exp_done));
        check({tag, "_hold"},  32'(core_hold),    32'(!exp_done));
        check({tag, "_busy"},  32'(busy),         32'd0);
        check({tag, "_ready"}, 32'(in_ready),     32'd0);
        check({tag, "_wl"},    32'(words_loaded), 32'(n));
        check({tag, "_wecnt"}, 32'(we_cnt),       32'(n));
        check({tag, "_sb"},    32'(sb.size()),    32'd0);
    endtask

    task automatic fill_random(input int n);
        for (int i = 0; i < n; i++) words[i] = 16'($urandom);
    endtask

    initial begin
        rst      = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        gaps     = 1'b0;
        we_cnt   = 0;
        run_chk  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_hold",  32'(core_hold),    32'd1);
        check("rst_ready", 32'(in_ready),     32'd0);
        check("rst_we",    32'(im_we),        32'd0);
        check("rst_busy",  32'(busy),         32'd0);
        check("rst_done",  32'(done),         32'd0);
        check("rst_error", 32'(error),        32'd0);
        check("rst_addr",  32'(im_addr),      32'd0);
        check("rst_wdata", 32'(im_wdata),     32'd0);
        check("rst_wl",    32'(words_loaded), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Two-word frame; XOR of 00 02 12 34 AB CD is 42.
        words[0] = 16'h1234;
        words[1] = 16'hABCD;
        pulse_start();
        check("start_busy",  32'(busy),     32'd1);
        check("start_ready", 32'(in_ready), 32'd1);
        send_frame(2, 1'b0, 8'h00, 1'b0);
        end_check("good", 1'b1, 2);
        check("good_last_addr", 32'(last_addr), 32'h1);

        // Restart after DONE, with random gaps on a longer frame.
        pulse_start();
        check("restart_done",  32'(done),         32'd0);
        check("restart_hold",  32'(core_hold),    32'd1);
        check("restart_wl",    32'(words_loaded), 32'd0);
        gaps = 1'b1;
        fill_random(9);
        send_frame(9, 1'b0, 8'h00, 1'b0);
        end_check("gaps", 1'b1, 9);
        check("gaps_last_addr", 32'(last_addr), 32'h8);
        gaps = 1'b0;

        // Same two-word frame with a wrong checksum byte.
        words[0] = 16'h1234;
        words[1] = 16'hABCD;
        pulse_start();
        send_frame(2, 1'b1, 8'h45, 1'b0);
        end_check("badchk", 1'b0, 2);

        // Zero length.
        pulse_start();
        we_cnt = 0;
        send_byte(8'h00);
        send_byte(8'h00);
        end_check("len0", 1'b0, 0);

        // One word over the limit.
        pulse_start();
        we_cnt = 0;
        send_byte(8'h04);
        send_byte(8'h01);
        end_check("len401", 1'b0, 0);

        // Byte offered with start must not be consumed; start mid-frame is ignored.
        fill_random(3);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        pulse_start();
        in_valid = 1'b0;
        send_frame(3, 1'b0, 8'h00, 1'b1);
        end_check("start_valid", 1'b1, 3);

        // Full-size frame.
        fill_random(1024);
        pulse_start();
        send_frame(1024, 1'b0, 8'h00, 1'b0);
        end_check("len400", 1'b1, 1024);
        check("len400_last_addr", 32'(last_addr), 32'h3FF);

        // Reset while waiting for a low word byte.
        words[0] = 16'h1234;
        pulse_start();
        run_chk = 8'h00;
        we_cnt  = 0;
        send_byte(8'h00);
        send_byte(8'h02);
        send_byte(8'h12);
        sb.push_back({10'd0, 16'h1234});
        send_byte(8'h34);
        send_byte(8'hAB);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_hold",  32'(core_hold), 32'd1);
        check("midrst_we",    32'(im_we),     32'd0);
        check("midrst_ready", 32'(in_ready),  32'd0);
        check("midrst_busy",  32'(busy),      32'd0);
        check("midrst_wecnt", 32'(we_cnt),    32'd1);
        check("midrst_sb",    32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Recovery after reset.
        words[0] = 16'hBEEF;
        pulse_start();
        send_frame(1, 1'b0, 8'h00, 1'b0);
        end_check("post_rst", 1'b1, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
